// File: rtl/mem_arb_pkg.sv
// Shared types and the arbitration rule for the single-port memory arbiter.
//   state_e    : arbiter FSM states
//   owner_e    : which requester currently owns the memory port
//   pick_owner : LSU wins unless IF is waiting and the LSU streak is saturated
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RESP
  } state_e;

  typedef enum logic {
    OWN_IF,
    OWN_LSU
  } owner_e;

  function automatic owner_e pick_owner(input logic if_req,
                                        input logic lsu_req,
                                        input logic streak_sat);
    return (lsu_req && !(if_req && streak_sat)) ? OWN_LSU : OWN_IF;
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the core's single-port memory between instruction fetch (IF) and
// the load/store unit (LSU). One transaction outstanding at a time; LSU has
// priority but IF is guaranteed a win after STREAK_MAX consecutive LSU wins.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   if_req/if_addr           fetch request (may abort before grant)
//   if_gnt/if_rvalid/if_rdata fetch grant and response
//   if_kill                  drop the pending fetch response (PC redirect)
//   lsu_req/we/addr/wdata/be load/store request, held until lsu_gnt
//   lsu_gnt/lsu_rvalid/lsu_rdata LSU grant and response/ack
//   mem_req/we/addr/wdata/be request to memory; mem_gnt accepts it
//   mem_rvalid/mem_rdata     memory response
//   busy                     arbiter not idle
//   protocol_err             sticky: response seen outside WAIT_RESP
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STREAK_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  input  logic                if_kill,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                lsu_req,
  input  logic                lsu_we,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_be,
  output logic                lsu_gnt,
  output logic                lsu_rvalid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy,
  output logic                protocol_err
);

  localparam int unsigned SW = (STREAK_MAX < 1) ? 1 : $clog2(STREAK_MAX + 1);
  localparam logic [SW-1:0] STREAK_SAT = SW'(STREAK_MAX);

  state_e        r_state, w_state_nxt;
  owner_e        r_owner, w_owner_nxt;
  logic [SW-1:0] r_streak, w_streak_nxt;
  logic          r_kill_pend, w_kill_pend_nxt;
  logic          r_protocol_err;
  logic          w_own_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_owner        <= OWN_IF;
      r_streak       <= '0;
      r_kill_pend    <= 1'b0;
      r_protocol_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_owner     <= w_owner_nxt;
      r_streak    <= w_streak_nxt;
      r_kill_pend <= w_kill_pend_nxt;
      if (mem_rvalid && (r_state != WAIT_RESP)) begin
        r_protocol_err <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_owner_nxt     = r_owner;
    w_streak_nxt    = r_streak;
    w_kill_pend_nxt = r_kill_pend;
    w_own_req       = (r_owner == OWN_LSU) ? lsu_req : if_req;
    if_gnt          = 1'b0;
    lsu_gnt         = 1'b0;
    if_rvalid       = 1'b0;
    lsu_rvalid      = 1'b0;
    if_rdata        = '0;
    lsu_rdata       = '0;
    mem_req         = 1'b0;
    mem_we          = 1'b0;
    mem_addr        = '0;
    mem_wdata       = '0;
    mem_be          = '0;

    case (r_state)
      IDLE: begin
        if (if_req || lsu_req) begin
          w_owner_nxt = pick_owner(if_req, lsu_req, r_streak == STREAK_SAT);
          // Streak counts LSU wins only while IF is actually waiting.
          if ((w_owner_nxt == OWN_LSU) && if_req) begin
            w_streak_nxt = (r_streak == STREAK_SAT) ? STREAK_SAT : r_streak + 1'b1;
          end else begin
            w_streak_nxt = '0;
          end
          w_state_nxt = ISSUE;
        end
      end

      ISSUE: begin
        mem_req = w_own_req;
        if (r_owner == OWN_LSU) begin
          mem_we    = lsu_we;
          mem_addr  = lsu_addr;
          mem_wdata = lsu_wdata;
          mem_be    = lsu_be;
        end else begin
          mem_addr  = if_addr;
          mem_be    = '1;
        end
        if (mem_req && mem_gnt) begin
          if (r_owner == OWN_LSU) begin
            lsu_gnt = 1'b1;
          end else begin
            if_gnt = 1'b1;
            if (if_kill) begin
              w_kill_pend_nxt = 1'b1;
            end
          end
          w_state_nxt = WAIT_RESP;
        end else if (!w_own_req) begin
          w_state_nxt = IDLE;
        end
      end

      WAIT_RESP: begin
        if (mem_rvalid) begin
          if (r_owner == OWN_LSU) begin
            lsu_rvalid = 1'b1;
            lsu_rdata  = mem_rdata;
          end else if (!(if_kill || r_kill_pend)) begin
            if_rvalid = 1'b1;
            if_rdata  = mem_rdata;
          end
          w_kill_pend_nxt = 1'b0;
          w_state_nxt     = IDLE;
        end else if ((r_owner == OWN_IF) && if_kill) begin
          w_kill_pend_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign busy         = (r_state != IDLE);
  assign protocol_err = r_protocol_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned BW   = DW / 8;
  localparam int unsigned SMAX = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_gnt, if_kill, if_rvalid;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          lsu_req, lsu_we, lsu_gnt, lsu_rvalid;
  logic [AW-1:0] lsu_addr;
  logic [DW-1:0] lsu_wdata, lsu_rdata;
  logic [BW-1:0] lsu_be;
  logic          mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [BW-1:0] mem_be;
  logic          busy, protocol_err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STREAK_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_kill(if_kill),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_be(lsu_be), .lsu_gnt(lsu_gnt), .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy), .protocol_err(protocol_err)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic drive_idle;
    if_req = 0; if_addr = '0; if_kill = 0;
    lsu_req = 0; lsu_we = 0; lsu_addr = '0; lsu_wdata = '0; lsu_be = '0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
  endtask

  task automatic chk_quiet(input string t);
    chk({t, "_if_gnt"},     if_gnt,     0);
    chk({t, "_lsu_gnt"},    lsu_gnt,    0);
    chk({t, "_if_rvalid"},  if_rvalid,  0);
    chk({t, "_lsu_rvalid"}, lsu_rvalid, 0);
    chk({t, "_mem_req"},    mem_req,    0);
    chk({t, "_if_rdata"},   if_rdata,   0);
    chk({t, "_lsu_rdata"},  lsu_rdata,  0);
    chk({t, "_mem_addr"},   mem_addr,   0);
    chk({t, "_mem_be"},     mem_be,     0);
    chk({t, "_mem_we"},     mem_we,     0);
  endtask

  // ---------------- random-phase reference model state ----------------
  logic [DW-1:0] ref_mem [16];   // what the program expects memory to hold
  logic [DW-1:0] tmem    [16];   // memory device contents, written via mem_*
  bit            stop_new;
  bit            if_done, lsu_done;
  bit            arb_ready, issuing, outstanding, kill_seen;
  bit            exp_own_lsu, resp_own_lsu, resp_is_store;
  int            fair_cnt;
  logic [DW-1:0] resp_exp;
  bit            m_pend;
  int            m_cnt;
  logic [DW-1:0] m_rdata;

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] a;
    a = $urandom;
    a[1:0] = 2'b00;
    return a;
  endfunction

  task automatic rand_cycle;
    logic [3:0]    idx;
    logic          rv_now;
    logic          exp_ifrv, exp_lsurv;
    // drive (just after the rising edge)
    if (if_done)  begin if_req = 0;  if_done = 0;  end
    if (lsu_done) begin lsu_req = 0; lsu_done = 0; end
    if (!stop_new && !if_req && ($urandom_range(0, 2) == 0)) begin
      if_req = 1; if_addr = rand_addr();
    end
    if (!stop_new && !lsu_req && ($urandom_range(0, 2) == 0)) begin
      lsu_req = 1; lsu_we = 1'($urandom_range(0, 1)); lsu_addr = rand_addr();
      lsu_wdata = $urandom; lsu_be = 4'($urandom_range(0, 15));
    end
    if_kill = ($urandom_range(0, 7) == 0);
    mem_gnt = 1'($urandom_range(0, 1));
    if (m_pend && (m_cnt == 0)) begin
      mem_rvalid = 1; mem_rdata = m_rdata;
    end else begin
      mem_rvalid = 0; mem_rdata = $urandom;
    end

    smp;
    rv_now = mem_rvalid;
    // checks against the transaction-level model
    chk("r_mem_req", mem_req, issuing);
    chk("r_if_gnt",  if_gnt,  issuing && !exp_own_lsu && mem_gnt);
    chk("r_lsu_gnt", lsu_gnt, issuing && exp_own_lsu && mem_gnt);
    if (issuing) begin
      chk("r_mem_addr", mem_addr, exp_own_lsu ? lsu_addr : if_addr);
      chk("r_mem_we",   mem_we,   exp_own_lsu ? lsu_we : 1'b0);
      chk("r_mem_be",   mem_be,   exp_own_lsu ? lsu_be : 4'hF);
      if (exp_own_lsu) chk("r_mem_wdata", mem_wdata, lsu_wdata);
    end
    exp_ifrv  = rv_now && outstanding && !resp_own_lsu && !(kill_seen || if_kill);
    exp_lsurv = rv_now && outstanding && resp_own_lsu;
    chk("r_if_rvalid",  if_rvalid,  exp_ifrv);
    chk("r_lsu_rvalid", lsu_rvalid, exp_lsurv);
    chk("r_if_rdata",   if_rdata,   exp_ifrv ? resp_exp : '0);
    chk("r_lsu_rdata",  lsu_rdata,  exp_lsurv ? (resp_is_store ? mem_rdata : resp_exp) : '0);

    // model updates
    if (outstanding && !rv_now && !resp_own_lsu && if_kill) kill_seen = 1;
    if (issuing && mem_gnt) begin
      issuing = 0; outstanding = 1; resp_own_lsu = exp_own_lsu;
      kill_seen = !exp_own_lsu && if_kill;
      if (exp_own_lsu) begin
        lsu_done = 1; resp_is_store = lsu_we;
        idx = lsu_addr[5:2];
        if (lsu_we) begin
          for (int b = 0; b < BW; b++)
            if (lsu_be[b]) ref_mem[idx][8*b +: 8] = lsu_wdata[8*b +: 8];
        end else begin
          resp_exp = ref_mem[idx];
        end
      end else begin
        if_done = 1; resp_is_store = 0;
        idx = if_addr[5:2];
        resp_exp = ref_mem[idx];
      end
    end
    if (arb_ready && (if_req || lsu_req)) begin
      exp_own_lsu = lsu_req && !(if_req && (fair_cnt == SMAX));
      fair_cnt = (exp_own_lsu && if_req) ? ((fair_cnt < SMAX) ? fair_cnt + 1 : SMAX) : 0;
      issuing = 1; arb_ready = 0;
    end
    if (rv_now) begin outstanding = 0; arb_ready = 1; end

    // memory device behaviour, driven only by the DUT's mem_* outputs
    if (rv_now) m_pend = 0;
    else if (m_pend && (m_cnt > 0)) m_cnt--;
    if (mem_req && mem_gnt) begin
      m_pend = 1; m_cnt = $urandom_range(0, 2);
      idx = mem_addr[5:2];
      if (mem_we) begin
        for (int b = 0; b < BW; b++)
          if (mem_be[b]) tmem[idx][8*b +: 8] = mem_wdata[8*b +: 8];
        m_rdata = $urandom;
      end else begin
        m_rdata = tmem[idx];
      end
    end
    step;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  logic [5:0] ord;
  logic [5:0] exp_ord;
  int         gcount;
  bit         pend;
  bit         drained;

  initial begin
    rst = 1;
    drive_idle();
    step; step;
    smp;
    chk_quiet("rst");
    chk("rst_busy", busy, 0);
    chk("rst_perr", protocol_err, 0);
    step; rst = 0;

    // Lone fetch
    if_req = 1; if_addr = 32'h100; mem_gnt = 1;
    smp;
    chk("f_c1_gnt", if_gnt, 0); chk("f_c1_memreq", mem_req, 0); chk("f_c1_busy", busy, 0);
    step; smp;
    chk("f_c2_gnt", if_gnt, 1); chk("f_c2_memreq", mem_req, 1);
    chk("f_c2_addr", mem_addr, 32'h100); chk("f_c2_we", mem_we, 0);
    chk("f_c2_be", mem_be, 4'hF); chk("f_c2_lsu_gnt", lsu_gnt, 0);
    step; if_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
    smp;
    chk("f_c3_rvalid", if_rvalid, 1); chk("f_c3_rdata", if_rdata, 32'hDEADBEEF);
    chk("f_c3_lsu_rvalid", lsu_rvalid, 0); chk("f_c3_lsu_rdata", lsu_rdata, 0);
    step; mem_rvalid = 0;
    smp;
    chk("f_c4_busy", busy, 0);

    // Store with delayed memory grant
    step; lsu_req = 1; lsu_we = 1; lsu_addr = 32'h2004; lsu_wdata = 32'h55AA; lsu_be = 4'b0011;
    smp;
    chk("s_idle_memreq", mem_req, 0);
    for (int i = 0; i < 3; i++) begin
      step; smp;
      chk("s_wait_memreq", mem_req, 1); chk("s_wait_we", mem_we, 1);
      chk("s_wait_addr", mem_addr, 32'h2004); chk("s_wait_wdata", mem_wdata, 32'h55AA);
      chk("s_wait_be", mem_be, 4'b0011); chk("s_wait_gnt", lsu_gnt, 0);
    end
    step; mem_gnt = 1;
    smp;
    chk("s_gnt", lsu_gnt, 1); chk("s_gnt_if", if_gnt, 0);
    step; lsu_req = 0; lsu_we = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = '0;
    smp;
    chk("s_ack", lsu_rvalid, 1); chk("s_ack_if", if_rvalid, 0);
    step; mem_rvalid = 0;
    smp;
    chk("s_busy", busy, 0);

    // Contention: expected grant order L,L,L,L,I,L
    step; if_req = 1; if_addr = 32'h300; lsu_req = 1; lsu_addr = 32'h400; mem_gnt = 1;
    gcount = 0; pend = 0; ord = '0; exp_ord = 6'b101111;
    for (int c = 0; c < 60 && gcount < 6; c++) begin
      smp;
      if (if_gnt || lsu_gnt) begin
        chk("cont_excl", if_gnt && lsu_gnt, 0);
        ord[gcount] = lsu_gnt;
        gcount++;
        pend = 1;
      end
      step; mem_rvalid = pend; pend = 0;
    end
    chk("cont_count", gcount, 6);
    for (int k = 0; k < 6; k++) chk($sformatf("cont_grant%0d", k), ord[k], exp_ord[k]);
    if_req = 0; lsu_req = 0; mem_gnt = 0;
    smp;
    step; mem_rvalid = 0;
    smp;
    chk("cont_busy", busy, 0);

    // Fetch abort before grant
    step; if_req = 1; if_addr = 32'h500;
    smp;
    step; smp;
    chk("ab_memreq", mem_req, 1); chk("ab_gnt0", if_gnt, 0);
    step; if_req = 0;
    smp;
    chk("ab_drop_memreq", mem_req, 0); chk("ab_drop_gnt", if_gnt, 0);
    step; smp;
    chk("ab_busy", busy, 0);

    // Kill in the response cycle
    step; if_req = 1; if_addr = 32'h600; mem_gnt = 1;
    smp;
    step; smp;
    chk("k1_gnt", if_gnt, 1);
    step; if_req = 0; mem_gnt = 0; if_kill = 1; mem_rvalid = 1; mem_rdata = 32'h12345678;
    smp;
    chk("k1_rvalid", if_rvalid, 0); chk("k1_rdata", if_rdata, 0);
    step; if_kill = 0; mem_rvalid = 0;
    smp;
    chk("k1_busy", busy, 0);

    // Kill earlier in WAIT_RESP is remembered
    step; if_req = 1; if_addr = 32'h700; mem_gnt = 1;
    smp;
    step; smp;
    chk("k2_gnt", if_gnt, 1);
    step; if_req = 0; mem_gnt = 0; if_kill = 1;
    smp;
    chk("k2_wait_busy", busy, 1);
    step; if_kill = 0; mem_rvalid = 1; mem_rdata = 32'hCAFEF00D;
    smp;
    chk("k2_rvalid", if_rvalid, 0);
    step; mem_rvalid = 0;
    smp;
    chk("k2_busy", busy, 0); chk("k2_perr", protocol_err, 0);

    // Spurious response while idle
    step; mem_rvalid = 1; mem_rdata = 32'hFFFF0000;
    smp;
    chk("pe_if_rvalid", if_rvalid, 0); chk("pe_lsu_rvalid", lsu_rvalid, 0);
    step; mem_rvalid = 0;
    smp;
    chk("pe_set", protocol_err, 1);
    step; step; smp;
    chk("pe_sticky", protocol_err, 1);

    // Reset during WAIT_RESP, then an orphaned response
    step; if_req = 1; if_addr = 32'h800; mem_gnt = 1;
    smp;
    step; smp;
    chk("rw_gnt", if_gnt, 1);
    step; if_req = 0; mem_gnt = 0; rst = 1;
    smp;
    chk("rw_busy_before", busy, 1);
    step; rst = 0;
    smp;
    chk_quiet("rw");
    chk("rw_busy", busy, 0); chk("rw_perr", protocol_err, 0);
    step; mem_rvalid = 1; mem_rdata = 32'hABCD;
    smp;
    chk("orph_rvalid", if_rvalid, 0);
    step; mem_rvalid = 0;
    smp;
    chk("orph_perr", protocol_err, 1);

    // Randomized traffic against the reference model
    step; rst = 1; drive_idle();
    step; rst = 0;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = $urandom;
      tmem[i] = ref_mem[i];
    end
    stop_new = 0; if_done = 0; lsu_done = 0;
    arb_ready = 1; issuing = 0; outstanding = 0; kill_seen = 0;
    exp_own_lsu = 0; resp_own_lsu = 0; resp_is_store = 0; fair_cnt = 0;
    resp_exp = '0; m_pend = 0; m_cnt = 0; m_rdata = '0;
    for (int c = 0; c < 3000; c++) rand_cycle();
    stop_new = 1;
    drained = 0;
    for (int c = 0; c < 100 && !drained; c++) begin
      rand_cycle();
      if (!if_req && !lsu_req && !issuing && !outstanding && !m_pend) drained = 1;
    end
    if_kill = 0; mem_gnt = 0; mem_rvalid = 0;
    chk("r_drained", drained, 1);
    smp;
    chk("r_end_busy", busy, 0);
    chk("r_end_perr", protocol_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
